// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and writeback request types for the register-file
// writeback arbiter and its scoreboard.
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] wd;
  } wb_req_t;

  // Register x0 is architecturally zero: never written, never busy.
  function automatic logic is_x0(input reg_addr_t rd);
    return (rd == '0);
  endfunction

endpackage : regfile_pkg

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the writeback handshakes, issue/query scoreboard traffic and
// the register-file write port. The master side belongs to the pipeline
// (execute/memory/decode); the slave side belongs to the arbiter.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  // ALU writeback requester
  logic              alu_valid;
  logic              alu_ready;
  reg_addr_t         alu_rd;
  logic [XLEN-1:0]   alu_wd;

  // Load writeback requester
  logic              mem_valid;
  logic              mem_ready;
  reg_addr_t         mem_rd;
  logic [XLEN-1:0]   mem_wd;

  // Destination reservation at issue and decode hazard queries
  logic              issue_valid;
  reg_addr_t         issue_rd;
  reg_addr_t         q1_rs;
  reg_addr_t         q2_rs;
  logic              q1_busy;
  logic              q2_busy;

  // Register-file write port (we3/a3/wd3)
  logic              rf_we;
  reg_addr_t         rf_a3;
  logic [XLEN-1:0]   rf_wd;

  modport master (
    output alu_valid, alu_rd, alu_wd,
    output mem_valid, mem_rd, mem_wd,
    output issue_valid, issue_rd, q1_rs, q2_rs,
    input  alu_ready, mem_ready, q1_busy, q2_busy,
    input  rf_we, rf_a3, rf_wd
  );

  modport slave (
    input  alu_valid, alu_rd, alu_wd,
    input  mem_valid, mem_rd, mem_wd,
    input  issue_valid, issue_rd, q1_rs, q2_rs,
    output alu_ready, mem_ready, q1_busy, q2_busy,
    output rf_we, rf_a3, rf_wd
  );

endinterface : regfile_wb_arbiter_if

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Busy scoreboard: one bit per architectural register, set when an
// instruction reserving that destination issues and cleared when the
// register file is written. Queries read the registered bits only, so a
// reservation becomes visible the cycle after issue and a clear becomes
// visible the cycle after the write.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      set_en,
  input  reg_addr_t set_rd,
  input  logic      clr_en,
  input  reg_addr_t clr_rd,
  input  reg_addr_t q1_rs,
  input  reg_addr_t q2_rs,
  output logic      q1_busy,
  output logic      q2_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;

  // Per-register decode of the set and clear requests; x0 never matches.
  assign set_vec[0] = 1'b0;
  assign clr_vec[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_decode
      assign set_vec[gi] = set_en && (set_rd == reg_addr_t'(gi));
      assign clr_vec[gi] = clr_en && (clr_rd == reg_addr_t'(gi));
    end
  endgenerate

  // Next busy state: a same-cycle set overrides the clear so the newer
  // reservation survives the retiring write of an older one.
  always_comb begin
    busy_d    = set_vec | (busy_q & ~clr_vec);
    busy_d[0] = 1'b0;
  end

  // Busy bit register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Hazard queries see only the registered state (no bypass).
  always_comb begin
    q1_busy = busy_q[q1_rs];
    q2_busy = busy_q[q2_rs];
  end

endmodule : regfile_scoreboard

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Loads win by default; an ALU result that has been held off for
// STARVE_LIMIT consecutive cycles wins the next arbitration once.
// The winning request is written one cycle after acceptance through
// registered rf_we/rf_a3/rf_wd. A busy scoreboard tracks pending
// destinations for decode hazard stalls.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  // Registered state
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             rf_we_q,      rf_we_d;
  reg_addr_t        rf_a3_q,      rf_a3_d;
  logic [XLEN-1:0]  rf_wd_q,      rf_wd_d;

  // Arbitration signals
  wb_req_t alu_req;
  wb_req_t mem_req;
  wb_req_t win_req;
  logic    starve_hit;
  logic    alu_ready;
  logic    mem_ready;
  logic    alu_acc;
  logic    mem_acc;
  logic    any_acc;

  assign alu_req = '{rd: bus.alu_rd, wd: bus.alu_wd};
  assign mem_req = '{rd: bus.mem_rd, wd: bus.mem_wd};

  // Ready/accept decision. Readies never look at the requester's own
  // valid, and the two accepts are mutually exclusive by construction:
  // with both valid exactly one of the readies is high.
  always_comb begin
    starve_hit = (starve_cnt_q == STARVE_MAX);
    mem_ready  = !(bus.alu_valid && starve_hit);
    alu_ready  = !bus.mem_valid || starve_hit;
    mem_acc    = bus.mem_valid && mem_ready;
    alu_acc    = bus.alu_valid && alu_ready;
    any_acc    = mem_acc || alu_acc;
    win_req    = mem_acc ? mem_req : alu_req;
  end

  // Next write-port values and starvation count. Accepted x0 requests
  // are consumed without a write; with no write the address/data hold.
  always_comb begin
    rf_we_d      = 1'b0;
    rf_a3_d      = rf_a3_q;
    rf_wd_d      = rf_wd_q;
    starve_cnt_d = '0;

    if (any_acc && !is_x0(win_req.rd)) begin
      rf_we_d = 1'b1;
      rf_a3_d = win_req.rd;
      rf_wd_d = win_req.wd;
    end

    // Count only while the ALU is actually waiting; accept or idle clears.
    if (bus.alu_valid && !alu_ready) begin
      starve_cnt_d = starve_hit ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  // Write-port and starvation registers; reset drops any accepted write.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q      <= 1'b0;
      rf_a3_q      <= '0;
      rf_wd_q      <= '0;
      starve_cnt_q <= '0;
    end else begin
      rf_we_q      <= rf_we_d;
      rf_a3_q      <= rf_a3_d;
      rf_wd_q      <= rf_wd_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Destination scoreboard: reserve at issue, release on the actual write.
  logic q1_busy_w;
  logic q2_busy_w;

  regfile_scoreboard u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (bus.issue_valid && !is_x0(bus.issue_rd)),
    .set_rd  (bus.issue_rd),
    .clr_en  (rf_we_q),
    .clr_rd  (rf_a3_q),
    .q1_rs   (bus.q1_rs),
    .q2_rs   (bus.q2_rs),
    .q1_busy (q1_busy_w),
    .q2_busy (q2_busy_w)
  );

  assign bus.alu_ready = alu_ready;
  assign bus.mem_ready = mem_ready;
  assign bus.q1_busy   = q1_busy_w;
  assign bus.q2_busy   = q2_busy_w;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_a3     = rf_a3_q;
  assign bus.rf_wd     = rf_wd_q;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, lone ALU write, memory
// priority with ALU starvation guard, scoreboard set/clear, x0 handling
// and reset during an accepted request.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
  endtask

  initial begin
    reset           = 1'b1;
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_wd      = '0;
    bus.mem_valid   = 1'b0;
    bus.mem_rd      = '0;
    bus.mem_wd      = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.q1_rs       = '0;
    bus.q2_rs       = '0;

    // Reset held for two cycles
    tick();
    tick();
    check("reset_rf_we", 32'(bus.rf_we), 32'd0);
    check("reset_rf_a3", 32'(bus.rf_a3), 32'd0);
    check("reset_rf_wd", bus.rf_wd, 32'd0);
    for (int rs = 0; rs < NREG; rs++) begin
      bus.q1_rs = reg_addr_t'(rs);
      bus.q2_rs = reg_addr_t'(NREG - 1 - rs);
      #1;
      check("reset_q1_busy", 32'(bus.q1_busy), 32'd0);
      check("reset_q2_busy", 32'(bus.q2_busy), 32'd0);
    end
    reset = 1'b0;
    tick();

    // Lone ALU request rd=5 wd=6
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_wd    = 32'h6;
    #1;
    check("lone_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    check("lone_rf_we", 32'(bus.rf_we), 32'd1);
    check("lone_rf_a3", 32'(bus.rf_a3), 32'd5);
    check("lone_rf_wd", bus.rf_wd, 32'h0000_0006);
    tick();
    check("lone_rf_we_off", 32'(bus.rf_we), 32'd0);
    check("lone_rf_a3_hold", 32'(bus.rf_a3), 32'd5);

    // Contention: memory wins four times, then the starved ALU wins once
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd9;
    bus.mem_wd    = 32'h4;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_wd    = 32'h33;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_mem_ready", 32'(bus.mem_ready), 32'd1);
      check("cont_alu_ready", 32'(bus.alu_ready), 32'd0);
      tick();
      check("cont_mem_rf_we", 32'(bus.rf_we), 32'd1);
      check("cont_mem_rf_a3", 32'(bus.rf_a3), 32'd9);
      check("cont_mem_rf_wd", bus.rf_wd, 32'h4);
    end
    #1;
    check("starve_mem_ready", 32'(bus.mem_ready), 32'd0);
    check("starve_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    check("starve_rf_we", 32'(bus.rf_we), 32'd1);
    check("starve_rf_a3", 32'(bus.rf_a3), 32'd3);
    check("starve_rf_wd", bus.rf_wd, 32'h33);
    // Counter back to zero: memory wins again
    #1;
    check("after_mem_ready", 32'(bus.mem_ready), 32'd1);
    check("after_alu_ready", 32'(bus.alu_ready), 32'd0);
    tick();
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
    check("after_rf_a3", 32'(bus.rf_a3), 32'd9);
    tick();
    check("idle_rf_we", 32'(bus.rf_we), 32'd0);

    // Scoreboard: reserve rd=7, visible the next cycle
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    bus.q1_rs       = 5'd7;
    bus.q2_rs       = 5'd7;
    #1;
    check("sb_no_bypass", 32'(bus.q1_busy), 32'd0);
    tick();
    bus.issue_valid = 1'b0;
    check("sb_q1_set", 32'(bus.q1_busy), 32'd1);
    check("sb_q2_set", 32'(bus.q2_busy), 32'd1);
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd7;
    bus.mem_wd    = 32'h77;
    tick();
    bus.mem_valid = 1'b0;
    check("sb_wr_rf_we", 32'(bus.rf_we), 32'd1);
    check("sb_wr_rf_a3", 32'(bus.rf_a3), 32'd7);
    check("sb_busy_in_wr", 32'(bus.q1_busy), 32'd1);
    tick();
    check("sb_cleared", 32'(bus.q1_busy), 32'd0);

    // Set and clear of rd=7 in the same cycle: set wins
    bus.issue_valid = 1'b1;
    tick();
    bus.issue_valid = 1'b0;
    check("sb_reserve2", 32'(bus.q1_busy), 32'd1);
    bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid   = 1'b0;
    bus.issue_valid = 1'b1;
    check("sb_wr2_rf_we", 32'(bus.rf_we), 32'd1);
    tick();
    bus.issue_valid = 1'b0;
    check("sb_set_wins", 32'(bus.q1_busy), 32'd1);
    bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid = 1'b0;
    tick();
    check("sb_cleared2", 32'(bus.q1_busy), 32'd0);

    // x0: request consumed without a write, never busy
    bus.alu_valid   = 1'b1;
    bus.alu_rd      = 5'd0;
    bus.alu_wd      = 32'hFFFF_FFFF;
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd0;
    bus.q1_rs       = 5'd0;
    #1;
    check("x0_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    bus.alu_valid   = 1'b0;
    bus.issue_valid = 1'b0;
    check("x0_rf_we", 32'(bus.rf_we), 32'd0);
    check("x0_q1_busy", 32'(bus.q1_busy), 32'd0);

    // Reset in the cycle a request is accepted
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd12;
    tick();
    bus.issue_rd = 5'd20;
    tick();
    bus.issue_valid = 1'b0;
    bus.q1_rs       = 5'd12;
    bus.q2_rs       = 5'd20;
    #1;
    check("rst_pre_q1", 32'(bus.q1_busy), 32'd1);
    check("rst_pre_q2", 32'(bus.q2_busy), 32'd1);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd12;
    bus.alu_wd    = 32'hAB;
    reset         = 1'b1;
    #1;
    check("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    reset         = 1'b0;
    bus.alu_valid = 1'b0;
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_q1_busy", 32'(bus.q1_busy), 32'd0);
    check("rst_q2_busy", 32'(bus.q2_busy), 32'd0);
    tick();
    check("rst_rf_we_after", 32'(bus.rf_we), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
